// File: rtl/quad_encoder_pkg.sv
// Shared types and helpers for the quadrature encoder bank.
package quad_encoder_pkg;

  // Direction FSM states; ERR is parked until AB returns to 11.
  typedef enum logic [2:0] {IDLE, R1, R2, R3, L1, L2, L3, ERR} qstate_t;

  // Filtered AB codes, A in bit 1, B in bit 0.
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;

  // Position of an AB code in the forward sequence 11->10->00->01.
  function automatic logic [1:0] gray_idx(logic [1:0] ab);
    unique case (ab)
      AB_11:   gray_idx = 2'd0;
      AB_10:   gray_idx = 2'd1;
      AB_00:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  // AB value a state expects to see while resting in it.
  function automatic logic [1:0] state_ab(qstate_t s);
    case (s)
      R1, L3:  state_ab = AB_10;
      R2, L2:  state_ab = AB_00;
      R3, L1:  state_ab = AB_01;
      default: state_ab = AB_11;
    endcase
  endfunction

  // Wrapping position arithmetic over 0..max.
  function automatic int unsigned next_pos(int unsigned pos, logic up, int unsigned max);
    if (up) return (pos >= max) ? 0 : pos + 1;
    else    return (pos == 0) ? max : pos - 1;
  endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One encoder channel: 2-flop sync, per-bit debounce, direction FSM, wrapping counter.
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int unsigned POS_MAX      = 19,
  parameter int unsigned POS_W        = $clog2(POS_MAX + 1),
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter bit          COUNT_X4     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clear_i,
  output logic [POS_W-1:0] pos_o,
  output logic             step_o,
  output logic             dir_o,
  output logic             err_o
);

  logic [1:0] ab_meta_q, ab_sync_q, ab_filt;
  qstate_t    state_q, state_d;
  logic       cnt_up, cnt_dn, enter_err;
  logic [POS_W-1:0] pos_q, pos_d;
  logic       step_q, step_d, dir_q, dir_d, err_q;

  // Two-flop synchroniser for the raw pins, idle-high after reset.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      ab_meta_q <= 2'b11;
      ab_sync_q <= 2'b11;
    end else begin
      ab_meta_q <= {a_i, b_i};
      ab_sync_q <= ab_meta_q;
    end
  end

  if (DEBOUNCE_CYC == 0) begin : g_bypass
    assign ab_filt = ab_sync_q;
  end else begin : g_filt
    localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);
    for (genvar i = 0; i < 2; i++) begin : g_bit
      logic [CntW-1:0] cnt_q;
      logic            filt_q;
      // Filtered bit follows sync only after DEBOUNCE_CYC cycles of disagreement.
      always_ff @(posedge clk) begin
        if (reset_i) begin
          cnt_q  <= '0;
          filt_q <= 1'b1;
        end else if (ab_sync_q[i] == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
          cnt_q  <= '0;
          filt_q <= ab_sync_q[i];
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
      assign ab_filt[i] = filt_q;
    end
  end

  // Next state and count decode; the state itself encodes the last accepted AB value.
  always_comb begin
    logic [1:0] cur_ab;
    logic [1:0] idx_fwd;
    state_d   = state_q;
    cnt_up    = 1'b0;
    cnt_dn    = 1'b0;
    enter_err = 1'b0;
    cur_ab    = state_ab(state_q);
    idx_fwd   = gray_idx(cur_ab) + 2'd1;
    if (state_q == ERR) begin
      if (ab_filt == AB_11) state_d = IDLE;
    end else if (ab_filt != cur_ab) begin
      if ((ab_filt ^ cur_ab) == 2'b11) begin
        state_d   = ERR;
        enter_err = 1'b1;
      end else begin
        unique case (state_q)
          IDLE:    state_d = (ab_filt == AB_10) ? R1 : L1;
          R1:      state_d = (ab_filt == AB_11) ? IDLE : R2;
          R2:      state_d = (ab_filt == AB_10) ? R1 : R3;
          R3:      state_d = (ab_filt == AB_00) ? R2 : IDLE;
          L1:      state_d = (ab_filt == AB_11) ? IDLE : L2;
          L2:      state_d = (ab_filt == AB_01) ? L1 : L3;
          L3:      state_d = (ab_filt == AB_00) ? L2 : IDLE;
          default: state_d = ERR;
        endcase
        if (COUNT_X4) begin
          cnt_up = (gray_idx(ab_filt) == idx_fwd);
          cnt_dn = !cnt_up;
        end else begin
          cnt_up = (state_q == R3) && (ab_filt == AB_11);
          cnt_dn = (state_q == L3) && (ab_filt == AB_11);
        end
      end
    end
  end

  // Position update; clear overrides a same-cycle count and leaves dir untouched.
  always_comb begin
    pos_d  = pos_q;
    step_d = 1'b0;
    dir_d  = dir_q;
    if (clear_i) begin
      pos_d = '0;
    end else if (cnt_up || cnt_dn) begin
      pos_d  = POS_W'(next_pos(32'(pos_q), cnt_up, POS_MAX));
      step_d = 1'b1;
      dir_d  = cnt_up;
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      pos_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= enter_err;
    end
  end

  assign pos_o  = pos_q;
  assign step_o = step_q;
  assign dir_o  = dir_q;
  assign err_o  = err_q;

endmodule

// File: rtl/quad_encoder_bank.sv
// Bank of independent quadrature encoder channels with packed outputs.
module quad_encoder_bank
  import quad_encoder_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned POS_MAX      = 19,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter bit          COUNT_X4     = 1'b0,
  // Derived; leave at default.
  parameter int unsigned POS_W        = $clog2(POS_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [NUM_CH-1:0]       A_i,
  input  logic [NUM_CH-1:0]       B_i,
  input  logic [NUM_CH-1:0]       clear_i,
  output logic [NUM_CH*POS_W-1:0] pos_o,
  output logic [NUM_CH-1:0]       step_o,
  output logic [NUM_CH-1:0]       dir_o,
  output logic [NUM_CH-1:0]       err_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    quad_encoder_channel #(
      .POS_MAX      (POS_MAX),
      .POS_W        (POS_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .COUNT_X4     (COUNT_X4)
    ) u_ch (
      .clk     (clk),
      .reset_i (reset_i),
      .a_i     (A_i[c]),
      .b_i     (B_i[c]),
      .clear_i (clear_i[c]),
      .pos_o   (pos_o[c*POS_W +: POS_W]),
      .step_o  (step_o[c]),
      .dir_o   (dir_o[c]),
      .err_o   (err_o[c])
    );
  end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Directed bench: one x1 and one x4 bank share the same pin stimulus.
module tb_quad_encoder_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] a, b, clear;
  logic [9:0] pos1x, pos4x;
  logic [1:0] step1x, dir1x, err1x, step4x, dir4x, err4x;

  int total = 0;
  int bad   = 0;
  int ns1_0 = 0, ns1_1 = 0, ne1_0 = 0, ns4_0 = 0, ne4_0 = 0;

  always #5 clk = ~clk;

  quad_encoder_bank #(
    .NUM_CH (2), .POS_MAX (19), .DEBOUNCE_CYC (4), .COUNT_X4 (1'b0)
  ) dut (
    .clk (clk), .reset_i (reset), .A_i (a), .B_i (b), .clear_i (clear),
    .pos_o (pos1x), .step_o (step1x), .dir_o (dir1x), .err_o (err1x)
  );

  quad_encoder_bank #(
    .NUM_CH (2), .POS_MAX (19), .DEBOUNCE_CYC (4), .COUNT_X4 (1'b1)
  ) dut4 (
    .clk (clk), .reset_i (reset), .A_i (a), .B_i (b), .clear_i (clear),
    .pos_o (pos4x), .step_o (step4x), .dir_o (dir4x), .err_o (err4x)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (step1x[0]) ns1_0 <= ns1_0 + 1;
    if (step1x[1]) ns1_1 <= ns1_1 + 1;
    if (err1x[0])  ne1_0 <= ne1_0 + 1;
    if (step4x[0]) ns4_0 <= ns4_0 + 1;
    if (err4x[0])  ne4_0 <= ne4_0 + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [1:0] ab0, input logic [1:0] ab1);
    a = {ab1[1], ab0[1]};
    b = {ab1[0], ab0[0]};
  endtask

  // Full detent cycle on channel 0, channel 1 resting.
  task automatic cycle0(input bit right);
    if (right) begin
      drive(2'b10, 2'b11); hold(10); drive(2'b00, 2'b11); hold(10);
      drive(2'b01, 2'b11); hold(10);
    end else begin
      drive(2'b01, 2'b11); hold(10); drive(2'b00, 2'b11); hold(10);
      drive(2'b10, 2'b11); hold(10);
    end
    drive(2'b11, 2'b11); hold(10);
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 2'b00; drive(2'b11, 2'b11);
    hold(2);
    reset = 1'b0;
    hold(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 2'b00; drive(2'b11, 2'b11);
    hold(2);
    total++; if (pos1x !== 10'd0) begin bad++; $display("FAIL reset_pos got=%0h want=0", pos1x); end
    total++; if (pos4x !== 10'd0) begin bad++; $display("FAIL reset_pos4 got=%0h want=0", pos4x); end
    total++; if (step1x !== 2'b00) begin bad++; $display("FAIL reset_step got=%b want=00", step1x); end
    total++; if (dir1x !== 2'b00) begin bad++; $display("FAIL reset_dir got=%b want=00", dir1x); end
    total++; if (err1x !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", err1x); end
    reset = 1'b0;
    hold(2);
  endtask

  task automatic test_right_x1();
    int s0 = ns1_0, s4 = ns4_0;
    cycle0(1'b1);
    total++; if (pos1x[4:0] !== 5'd1) begin bad++; $display("FAIL right_pos got=%0d want=1", pos1x[4:0]); end
    total++; if (ns1_0 - s0 !== 1) begin bad++; $display("FAIL right_steps got=%0d want=1", ns1_0 - s0); end
    total++; if (dir1x[0] !== 1'b1) begin bad++; $display("FAIL right_dir got=%b want=1", dir1x[0]); end
    total++; if (pos1x[9:5] !== 5'd0) begin bad++; $display("FAIL right_ch1 got=%0d want=0", pos1x[9:5]); end
    total++; if (pos4x[4:0] !== 5'd4) begin bad++; $display("FAIL right_pos4 got=%0d want=4", pos4x[4:0]); end
    total++; if (ns4_0 - s4 !== 4) begin bad++; $display("FAIL right_steps4 got=%0d want=4", ns4_0 - s4); end
  endtask

  task automatic test_wrap();
    cycle0(1'b0);
    cycle0(1'b0);
    total++; if (pos1x[4:0] !== 5'd19) begin bad++; $display("FAIL wrap_down got=%0d want=19", pos1x[4:0]); end
    cycle0(1'b1);
    total++; if (pos1x[4:0] !== 5'd0) begin bad++; $display("FAIL wrap_up got=%0d want=0", pos1x[4:0]); end
    total++; if (dir1x[0] !== 1'b1) begin bad++; $display("FAIL wrap_up_dir got=%b want=1", dir1x[0]); end
    cycle0(1'b0);
    total++; if (pos1x[4:0] !== 5'd19) begin bad++; $display("FAIL wrap_left got=%0d want=19", pos1x[4:0]); end
    total++; if (dir1x[0] !== 1'b0) begin bad++; $display("FAIL wrap_left_dir got=%b want=0", dir1x[0]); end
  endtask

  task automatic test_x4_backtrack();
    int s4, e4;
    do_reset();
    s4 = ns4_0; e4 = ne4_0;
    drive(2'b10, 2'b11); hold(10);
    total++; if (pos4x[4:0] !== 5'd1) begin bad++; $display("FAIL x4_first got=%0d want=1", pos4x[4:0]); end
    drive(2'b00, 2'b11); hold(10);
    total++; if (pos4x[4:0] !== 5'd2) begin bad++; $display("FAIL x4_second got=%0d want=2", pos4x[4:0]); end
    drive(2'b10, 2'b11); hold(10);
    total++; if (pos4x[4:0] !== 5'd1) begin bad++; $display("FAIL x4_back got=%0d want=1", pos4x[4:0]); end
    total++; if (dir4x[0] !== 1'b0) begin bad++; $display("FAIL x4_back_dir got=%b want=0", dir4x[0]); end
    total++; if (ns4_0 - s4 !== 3) begin bad++; $display("FAIL x4_steps got=%0d want=3", ns4_0 - s4); end
    total++; if (ne4_0 - e4 !== 0) begin bad++; $display("FAIL x4_err got=%0d want=0", ne4_0 - e4); end
    total++; if (pos1x[4:0] !== 5'd0) begin bad++; $display("FAIL x4_x1pos got=%0d want=0", pos1x[4:0]); end
  endtask

  task automatic test_glitch_err();
    int s1, s4, e1;
    do_reset();
    s1 = ns1_0; s4 = ns4_0; e1 = ne1_0;
    drive(2'b01, 2'b11); hold(3);
    drive(2'b11, 2'b11); hold(10);
    total++; if (ns4_0 - s4 !== 0) begin bad++; $display("FAIL glitch_steps4 got=%0d want=0", ns4_0 - s4); end
    total++; if (ne1_0 - e1 !== 0) begin bad++; $display("FAIL glitch_err got=%0d want=0", ne1_0 - e1); end
    drive(2'b00, 2'b11); hold(10);
    total++; if (ne1_0 - e1 !== 1) begin bad++; $display("FAIL jump_err got=%0d want=1", ne1_0 - e1); end
    total++; if (ns1_0 - s1 !== 0) begin bad++; $display("FAIL jump_steps got=%0d want=0", ns1_0 - s1); end
    total++; if (pos4x[4:0] !== 5'd0) begin bad++; $display("FAIL jump_pos4 got=%0d want=0", pos4x[4:0]); end
    drive(2'b11, 2'b11); hold(10);
    cycle0(1'b1);
    total++; if (pos1x[4:0] !== 5'd1) begin bad++; $display("FAIL recover_pos got=%0d want=1", pos1x[4:0]); end
    total++; if (pos4x[4:0] !== 5'd4) begin bad++; $display("FAIL recover_pos4 got=%0d want=4", pos4x[4:0]); end
  endtask

  task automatic test_clear_collision();
    int s0, s1;
    do_reset();
    s0 = ns1_0; s1 = ns1_1;
    for (int n = 0; n < 2; n++) begin
      drive(2'b10, 2'b10); hold(10);
      drive(2'b00, 2'b00); hold(10);
      drive(2'b01, 2'b01); hold(10);
      drive(2'b11, 2'b11);
      if (n == 0) begin
        hold(10);
        total++; if (pos1x[9:5] !== 5'd1) begin bad++; $display("FAIL clr_pre got=%0d want=1", pos1x[9:5]); end
      end else begin
        // Clear window straddles the edge where channel 1 completes its count.
        hold(5); clear = 2'b10; hold(3); clear = 2'b00; hold(5);
      end
    end
    total++; if (pos1x[9:5] !== 5'd0) begin bad++; $display("FAIL clr_pos1 got=%0d want=0", pos1x[9:5]); end
    total++; if (ns1_1 - s1 !== 1) begin bad++; $display("FAIL clr_steps1 got=%0d want=1", ns1_1 - s1); end
    total++; if (dir1x[1] !== 1'b1) begin bad++; $display("FAIL clr_dir1 got=%b want=1", dir1x[1]); end
    total++; if (pos1x[4:0] !== 5'd2) begin bad++; $display("FAIL clr_pos0 got=%0d want=2", pos1x[4:0]); end
    total++; if (ns1_0 - s0 !== 2) begin bad++; $display("FAIL clr_steps0 got=%0d want=2", ns1_0 - s0); end
  endtask

  task automatic test_reset_midrotation();
    int s1;
    do_reset();
    cycle0(1'b1);
    drive(2'b10, 2'b11); hold(10);
    drive(2'b00, 2'b11); hold(10);
    reset = 1'b1;
    tick();
    total++; if (pos1x !== 10'd0) begin bad++; $display("FAIL mid_reset_pos got=%0h want=0", pos1x); end
    total++; if (dir1x !== 2'b00) begin bad++; $display("FAIL mid_reset_dir got=%b want=00", dir1x); end
    total++; if (pos4x !== 10'd0) begin bad++; $display("FAIL mid_reset_pos4 got=%0h want=0", pos4x); end
    reset = 1'b0;
    s1 = ns1_0;
    drive(2'b01, 2'b11); hold(10);
    drive(2'b11, 2'b11); hold(10);
    total++; if (pos1x[4:0] !== 5'd0) begin bad++; $display("FAIL mid_after_pos got=%0d want=0", pos1x[4:0]); end
    total++; if (ns1_0 - s1 !== 0) begin bad++; $display("FAIL mid_after_steps got=%0d want=0", ns1_0 - s1); end
  endtask

  initial begin
    reset = 1'b1;
    clear = 2'b00;
    drive(2'b11, 2'b11);
    test_reset();
    test_right_x1();
    test_wrap();
    test_x4_backtrack();
    test_glitch_err();
    test_clear_collision();
    test_reset_midrotation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
